// File: rtl/count_seq_pkg.sv
// count_seq_pkg: definitions shared by the count sequencer and its users.
//
// Contents:
//   state_t         3-bit FSM state type
//   ST_IDLE..ST_DONE controller states (legacy-compatible constants)
//   ONE_SHOT        mode encoding: run cfg_reps passes then stop
//   CONTINUOUS      mode encoding: run passes until aborted
package count_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_PAUSE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic ONE_SHOT   = 1'b0;
    localparam logic CONTINUOUS = 1'b1;

endpackage

// File: rtl/count_sequencer.sv
// count_sequencer: controller for an external synchronous up counter.
// Latches a run configuration over valid/ready, then drives the counter's
// clear/enable to run passes of 0..limit, with pause and abort.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous reset, active-low
//   cfg_valid  in   configuration offered
//   cfg_ready  out  configuration can be accepted (IDLE or DONE)
//   cfg_limit  in   terminal count, inclusive
//   cfg_reps   in   passes for one-shot mode (0 treated as 1)
//   cfg_mode   in   ONE_SHOT / CONTINUOUS
//   start      in   begin a run (sampled in IDLE/DONE)
//   pause      in   level; holds the counter while high
//   abort      in   cancels a run; highest priority
//   cnt_val    in   current counter value
//   cnt_en     out  counter increment enable
//   cnt_clr    out  counter synchronous clear
//   busy       out  high in CLEAR, RUN, PAUSE
//   wrap       out  one-cycle pulse when a pass reaches its limit
//   done       out  one-cycle pulse when a one-shot run completes
//   rep_left   out  passes remaining, including the current one
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic [REP_W-1:0] rep_left
);

    localparam logic [REP_W-1:0] ONE_REP = REP_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_left_q, rep_left_d;
    logic             mode_q, mode_d;

    logic cfg_acc;
    logic match;
    logic last_pass;

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign match     = (cnt_val == lim_q);
    assign last_pass = (mode_q == ONE_SHOT) && (rep_left_q == ONE_REP);
    assign busy      = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign rep_left  = rep_left_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        lim_d      = lim_q;
        reps_d     = reps_q;
        mode_d     = mode_q;
        rep_left_d = rep_left_q;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        wrap       = 1'b0;
        done       = 1'b0;

        if (cfg_acc) begin
            lim_d  = cfg_limit;
            mode_d = cfg_mode;
            reps_d = (cfg_reps == '0) ? ONE_REP : cfg_reps;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                // A config handshake in the same cycle takes precedence; a
                // still-high start is picked up on the following cycle.
                if (cfg_acc) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d    = ST_CLEAR;
                    rep_left_d = reps_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                cnt_clr = 1'b1;
                state_d = abort ? ST_IDLE : ST_RUN;
            end

            ST_RUN: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (match) begin
                    // End of a pass: restart the counter even if pausing now.
                    cnt_clr = 1'b1;
                    wrap    = 1'b1;
                    if (last_pass) begin
                        state_d = ST_DONE;
                    end else begin
                        if (mode_q == ONE_SHOT) begin
                            rep_left_d = rep_left_q - ONE_REP;
                        end
                        state_d = pause ? ST_PAUSE : ST_RUN;
                    end
                end else begin
                    cnt_en  = !pause;
                    state_d = pause ? ST_PAUSE : ST_RUN;
                end
            end

            ST_PAUSE: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q    <= ST_IDLE;
            lim_q      <= '1;
            reps_q     <= ONE_REP;
            mode_q     <= ONE_SHOT;
            rep_left_q <= ONE_REP;
        end else begin
            state_q    <= state_d;
            lim_q      <= lim_d;
            reps_q     <= reps_d;
            mode_q     <= mode_d;
            rep_left_q <= rep_left_d;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: self-checking bench for count_sequencer.
// Provides the external 4-bit counter datapath, drives directed and
// randomized runs, and compares every output against expectations derived
// from pass arithmetic (position = cycle mod (limit+1)).
module tb_count_sequencer;

    localparam int WIDTH = 4;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_limit;
    logic [REP_W-1:0] cfg_reps;
    logic             cfg_mode;
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] cnt_val = '0;
    logic             cnt_en;
    logic             cnt_clr;
    logic             busy;
    logic             wrap;
    logic             done;
    logic [REP_W-1:0] rep_left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_limit (cfg_limit),
        .cfg_reps  (cfg_reps),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .cnt_val   (cnt_val),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done),
        .rep_left  (rep_left)
    );

    // Counter datapath: clear wins over enable.
    always @(posedge clk) begin
        if (cnt_clr)     cnt_val <= '0;
        else if (cnt_en) cnt_val <= cnt_val + 1'b1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [3:0] lim, input logic [3:0] reps, input logic mode);
        cfg_valid = 1'b1;
        cfg_limit = lim;
        cfg_reps  = reps;
        cfg_mode  = mode;
        #1;
        check("cfg_ready_at_load", 8'(cfg_ready), 8'd1);
        tick();
        cfg_valid = 1'b0;
        #1;
    endtask

    // One-shot run from IDLE with the given limit and effective pass count.
    task automatic run_oneshot(input int lim, input int reps);
        int pos;
        int pass;
        start = 1'b1;
        #1;
        check("idle_busy", 8'(busy), 8'd0);
        tick();
        start = 1'b0;
        #1;
        check("clear_clr",      8'(cnt_clr),  8'd1);
        check("clear_busy",     8'(busy),     8'd1);
        check("clear_rep_left", 8'(rep_left), 8'(reps));
        tick();
        for (int i = 0; i < reps * (lim + 1); i++) begin
            pos  = i % (lim + 1);
            pass = i / (lim + 1);
            check("run_cnt_val",  8'(cnt_val),  8'(pos));
            check("run_wrap",     8'(wrap),     8'(pos == lim));
            check("run_cnt_en",   8'(cnt_en),   8'(pos != lim));
            check("run_rep_left", 8'(rep_left), 8'(reps - pass));
            check("run_done",     8'(done),     8'd0);
            tick();
        end
        check("done_pulse",     8'(done),      8'd1);
        check("done_busy",      8'(busy),      8'd0);
        check("done_cfg_ready", 8'(cfg_ready), 8'd1);
        check("done_wrap",      8'(wrap),      8'd0);
        tick();
        check("after_done", 8'(done), 8'd0);
    endtask

    initial begin
        logic [3:0] rl;
        logic [3:0] rr;

        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_limit = '0;
        cfg_reps  = '0;
        cfg_mode  = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_cfg_ready", 8'(cfg_ready), 8'd1);
        check("rst_busy",      8'(busy),      8'd0);
        check("rst_cnt_en",    8'(cnt_en),    8'd0);
        check("rst_cnt_clr",   8'(cnt_clr),   8'd0);
        check("rst_wrap",      8'(wrap),      8'd0);
        check("rst_done",      8'(done),      8'd0);
        check("rst_rep_left",  8'(rep_left),  8'd1);
        reset = 1'b1;
        tick();

        // One-shot, limit 3, two passes.
        load_cfg(4'd3, 4'd2, 1'b0);
        run_oneshot(3, 2);

        // Continuous, limit 15: three full passes, then abort mid-pass.
        load_cfg(4'd15, 4'd5, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("cont_clear_clr", 8'(cnt_clr), 8'd1);
        tick();
        for (int i = 0; i < 54; i++) begin
            check("cont_cnt_val",  8'(cnt_val),  8'(i % 16));
            check("cont_wrap",     8'(wrap),     8'((i % 16) == 15));
            check("cont_rep_left", 8'(rep_left), 8'd5);
            check("cont_done",     8'(done),     8'd0);
            tick();
        end
        check("cont_pre_abort_val", 8'(cnt_val), 8'd6);
        abort = 1'b1;
        #1;
        check("abort_clr",  8'(cnt_clr), 8'd1);
        check("abort_wrap", 8'(wrap),    8'd0);
        check("abort_done", 8'(done),    8'd0);
        tick();
        abort = 1'b0;
        #1;
        check("abort_idle_busy",  8'(busy),      8'd0);
        check("abort_idle_done",  8'(done),      8'd0);
        check("abort_idle_ready", 8'(cfg_ready), 8'd1);
        check("abort_cnt_zero",   8'(cnt_val),   8'd0);
        tick();
        check("abort_no_done", 8'(done), 8'd0);

        // Pause held at cnt_val 2, limit 5.
        load_cfg(4'd5, 4'd1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_pause_val", 8'(cnt_val), 8'd2);
        pause = 1'b1;
        #1;
        check("pause_run_en",   8'(cnt_en), 8'd0);
        check("pause_run_wrap", 8'(wrap),   8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pause_val",  8'(cnt_val), 8'd2);
            check("pause_busy", 8'(busy),    8'd1);
            check("pause_wrap", 8'(wrap),    8'd0);
            check("pause_en",   8'(cnt_en),  8'd0);
        end
        tick();
        pause = 1'b0;
        #1;
        check("release_val", 8'(cnt_val), 8'd2);
        check("release_en",  8'(cnt_en),  8'd0);
        tick();
        for (int v = 2; v <= 5; v++) begin
            check("resume_val",  8'(cnt_val), 8'(v));
            check("resume_wrap", 8'(wrap),    8'(v == 5));
            check("resume_en",   8'(cnt_en),  8'(v != 5));
            tick();
        end
        check("pause_run_done", 8'(done), 8'd1);
        tick();

        // abort + pause + match in one RUN cycle.
        load_cfg(4'd1, 4'd1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("apm_val0", 8'(cnt_val), 8'd0);
        tick();
        check("apm_val1", 8'(cnt_val), 8'd1);
        abort = 1'b1;
        pause = 1'b1;
        #1;
        check("apm_wrap", 8'(wrap),    8'd0);
        check("apm_clr",  8'(cnt_clr), 8'd1);
        tick();
        abort = 1'b0;
        pause = 1'b0;
        #1;
        check("apm_idle_busy", 8'(busy), 8'd0);

        // Abort in IDLE has no effect.
        abort = 1'b1;
        #1;
        check("idle_abort_clr", 8'(cnt_clr), 8'd0);
        tick();
        check("idle_abort_ready", 8'(cfg_ready), 8'd1);
        abort = 1'b0;

        // pause + match: wrap and clear, then PAUSE.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pm_val1", 8'(cnt_val), 8'd1);
        pause = 1'b1;
        #1;
        check("pm_wrap", 8'(wrap),    8'd1);
        check("pm_clr",  8'(cnt_clr), 8'd1);
        check("pm_en",   8'(cnt_en),  8'd0);
        tick();
        check("pm_pause_busy", 8'(busy),    8'd1);
        check("pm_pause_val",  8'(cnt_val), 8'd0);
        check("pm_pause_wrap", 8'(wrap),    8'd0);
        check("pm_pause_clr",  8'(cnt_clr), 8'd0);
        check("pm_pause_en",   8'(cnt_en),  8'd0);
        pause = 1'b0;
        tick();
        check("pm_resume_en", 8'(cnt_en), 8'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("pm_abort_busy", 8'(busy), 8'd0);

        // limit 0, three passes; then reps 0 behaves as one pass.
        load_cfg(4'd0, 4'd3, 1'b0);
        run_oneshot(0, 3);
        load_cfg(4'd2, 4'd0, 1'b0);
        run_oneshot(2, 1);

        // cfg_valid held during a run stalls until DONE.
        load_cfg(4'd2, 4'd1, 1'b0);
        start = 1'b1;
        tick();
        start     = 1'b0;
        cfg_valid = 1'b1;
        cfg_limit = 4'd4;
        cfg_reps  = 4'd2;
        cfg_mode  = 1'b0;
        #1;
        check("stall_clear_ready", 8'(cfg_ready), 8'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("stall_run_ready", 8'(cfg_ready), 8'd0);
            tick();
        end
        check("stall_done",       8'(done),      8'd1);
        check("stall_done_ready", 8'(cfg_ready), 8'd1);
        tick();
        cfg_valid = 1'b0;
        #1;
        check("stall_idle_busy", 8'(busy), 8'd0);
        run_oneshot(4, 2);

        // Reset in the middle of a run restores defaults (limit 15, one pass).
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_ready",    8'(cfg_ready), 8'd1);
        check("mid_rst_busy",     8'(busy),      8'd0);
        check("mid_rst_en",       8'(cnt_en),    8'd0);
        check("mid_rst_clr",      8'(cnt_clr),   8'd0);
        check("mid_rst_wrap",     8'(wrap),      8'd0);
        check("mid_rst_done",     8'(done),      8'd0);
        check("mid_rst_rep_left", 8'(rep_left),  8'd1);
        reset = 1'b1;
        tick();
        run_oneshot(15, 1);

        // Randomized one-shot runs.
        for (int n = 0; n < 5; n++) begin
            rl = 4'($urandom_range(0, 15));
            rr = 4'($urandom_range(0, 4));
            load_cfg(rl, rr, 1'b0);
            run_oneshot(int'(rl), (rr == 4'd0) ? 1 : int'(rr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
